// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed common-anode 7-segment scanner for an hh:mm:ss time word.
// Snapshots the input once per frame, decodes binary bytes to decimal digits, supports field blinking.
module seven_seg_scanner #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 64,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] data_in,
  input  logic        blink_en,
  input  logic [2:0]  blank_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  dig_sel
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] count;
  logic [BLK_W-1:0] blink_cnt;
  logic [2:0]       idx;
  logic             phase;
  logic [23:0]      snapshot;
  logic             load_first;

  logic             slot_tick;
  logic             blink_wrap;
  logic [7:0]       field_v;
  logic             mask_bit;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [3:0]       digit;
  logic             blanked;
  logic             dp_slot;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic [5:0]       dig_sel_d;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 7'h40;
      4'd1:    seg_lut = 7'h79;
      4'd2:    seg_lut = 7'h24;
      4'd3:    seg_lut = 7'h30;
      4'd4:    seg_lut = 7'h19;
      4'd5:    seg_lut = 7'h12;
      4'd6:    seg_lut = 7'h02;
      4'd7:    seg_lut = 7'h78;
      4'd8:    seg_lut = 7'h00;
      4'd9:    seg_lut = 7'h10;
      default: seg_lut = 7'h7F;
    endcase
  endfunction

  assign slot_tick  = (count == CNT_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BLK_W'(BLINK_DIV - 1));

  always_comb begin
    field_v  = snapshot[23:16];
    mask_bit = blank_mask[2];
    case (idx)
      3'd0, 3'd1: begin
        field_v  = snapshot[7:0];
        mask_bit = blank_mask[0];
      end
      3'd2, 3'd3: begin
        field_v  = snapshot[15:8];
        mask_bit = blank_mask[1];
      end
      default: begin
        field_v  = snapshot[23:16];
        mask_bit = blank_mask[2];
      end
    endcase

    tens    = 4'(field_v / 8'd10);
    ones    = 4'(field_v % 8'd10);
    digit   = idx[0] ? tens : ones;
    blanked = blink_en & phase & mask_bit;
    // Separator dots sit after the hours and minutes fields and blink with the phase.
    dp_slot = ((idx == 3'd2) || (idx == 3'd4)) && !phase;

    if (blanked)
      seg_d = 7'h7F;
    else if (field_v > 8'd99)
      seg_d = 7'h3F;
    else
      seg_d = seg_lut(digit);

    dp_d = blanked ? 1'b1 : ~dp_slot;

    if (count < CNT_W'(GUARD))
      dig_sel_d = 6'h3F;
    else
      dig_sel_d = ~(6'b1 << idx);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      blink_cnt  <= '0;
      idx        <= 3'd0;
      phase      <= 1'b0;
      snapshot   <= 24'h0;
      load_first <= 1'b1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      dig_sel    <= 6'h3F;
    end else begin
      count     <= slot_tick ? '0 : count + CNT_W'(1);
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLK_W'(1);
      if (blink_wrap)
        phase <= ~phase;
      if (slot_tick)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      // Capture only at frame wrap (or right after reset) so a field never tears mid-scan.
      if (load_first || (slot_tick && (idx == 3'd5)))
        snapshot <= data_in;
      load_first <= 1'b0;
      seg        <= seg_d;
      dp         <= dp_d;
      dig_sel    <= dig_sel_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: stimulus pushes one expected entry per digit slot,
// a negedge monitor pops it when the digit strobes and checks every active cycle.
module tb_seven_seg_scanner;

  localparam int SCAN_DIV  = 8;
  localparam int GUARD     = 2;
  localparam int BLINK_DIV = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] data_in = 24'h0;
  logic        blink_en = 1'b0;
  logic [2:0]  blank_mask = 3'b000;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  dig_sel;

  seven_seg_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .GUARD     (GUARD),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .blink_en   (blink_en),
    .blank_mask (blank_mask),
    .seg        (seg),
    .dp         (dp),
    .dig_sel    (dig_sel)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // {dig_sel[5:0], seg[6:0], dp}
  logic [13:0] exp_q[$];

  // Hand-decoded segment patterns per vector, packed {idx5,...,idx0}
  logic [23:0] vec_data[7];
  logic [41:0] vec_seg[7];
  logic [5:0]  sel_tab[6];
  int          cur_vec;
  int          frame_vec;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_vec(input int v);
    cur_vec = v;
    data_in = vec_data[v];
  endtask

  task automatic push_slot(input int s);
    int          idx;
    int          ph;
    logic        blanked;
    logic [6:0]  e_seg;
    logic        e_dp;
    idx = s % 6;
    // Blink half-period is exactly four slots, so phase is constant within a slot.
    ph = (s / 4) % 2;
    blanked = blink_en && (ph == 1) && blank_mask[idx / 2];
    e_seg = blanked ? 7'h7F : vec_seg[frame_vec][idx * 7 +: 7];
    e_dp  = blanked ? 1'b1 : !(((idx == 2) || (idx == 4)) && (ph == 0));
    exp_q.push_back({sel_tab[idx], e_seg, e_dp});
  endtask

  task automatic apply_main(input int s);
    case (s)
      2:  set_vec(1);
      8:  set_vec(2);
      14: set_vec(3);
      18: begin blink_en = 1'b1; blank_mask = 3'b010; end
      26: set_vec(4);
      30: blank_mask = 3'b101;
      32: begin blink_en = 1'b0; blank_mask = 3'b111; end
      33: set_vec(5);
      default: ;
    endcase
  endtask

  // scoreboard monitor
  logic [13:0] cur;
  logic        in_run = 1'b0;
  logic        have_cur = 1'b0;
  logic        first_after = 1'b0;
  int          run_len = 0;
  int          since_rst = 0;

  always @(negedge clock) begin
    if (reset) begin
      in_run      = 1'b0;
      have_cur    = 1'b0;
      run_len     = 0;
      since_rst   = 0;
      first_after = 1'b1;
    end else begin
      since_rst++;
      if (dig_sel != 6'h3F) begin
        if (!in_run) begin
          if (first_after) begin
            check("guard_latency", since_rst, GUARD + 1);
            first_after = 1'b0;
          end
          if (exp_q.size() == 0) begin
            check("unexpected_digit", dig_sel, 6'h3F);
            have_cur = 1'b0;
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
          end
          in_run  = 1'b1;
          run_len = 0;
        end
        run_len++;
        if (have_cur) begin
          check("dig_sel", dig_sel, cur[13:8]);
          check("seg", seg, cur[7:1]);
          check("dp", dp, cur[0]);
        end
      end else if (in_run) begin
        check("active_len", run_len, SCAN_DIV - GUARD);
        in_run = 1'b0;
      end
    end
  end

  initial begin
    vec_data[0] = 24'h17_2B_05; vec_seg[0] = {7'h24, 7'h30, 7'h19, 7'h30, 7'h40, 7'h12};
    vec_data[1] = 24'h00_00_3B; vec_seg[1] = {7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h10};
    vec_data[2] = 24'h17_2B_96; vec_seg[2] = {7'h24, 7'h30, 7'h19, 7'h30, 7'h3F, 7'h3F};
    vec_data[3] = 24'h0C_38_63; vec_seg[3] = {7'h79, 7'h24, 7'h12, 7'h02, 7'h10, 7'h10};
    vec_data[4] = 24'h63_64_07; vec_seg[4] = {7'h10, 7'h10, 7'h3F, 7'h3F, 7'h40, 7'h78};
    vec_data[5] = 24'h4E_12_58; vec_seg[5] = {7'h78, 7'h00, 7'h79, 7'h00, 7'h00, 7'h00};
    vec_data[6] = 24'h01_02_03; vec_seg[6] = {7'h40, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30};
    sel_tab[0] = 6'h3E; sel_tab[1] = 6'h3D; sel_tab[2] = 6'h3B;
    sel_tab[3] = 6'h37; sel_tab[4] = 6'h2F; sel_tab[5] = 6'h1F;
    cur_vec   = 0;
    frame_vec = 0;

    // Power-up reset with the first time word already present.
    set_vec(0);
    #1 reset = 1'b1;
    wait_neg(3);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_dig_sel", dig_sel, 6'h3F);
    #1 reset = 1'b0;

    // Frames 0..7: tearing, '-' field, blinking, dots; stop mid idx 3 of frame 7.
    for (int s = 0; s < 46; s++) begin
      if (s % 6 == 0) frame_vec = cur_vec;
      apply_main(s);
      push_slot(s);
      if (s == 45) wait_neg(5);
      else wait_neg(8);
    end

    // Asynchronous reset in the middle of an active idx 3 slot.
    #1 reset = 1'b1;
    #1;
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    check("async_rst_dig_sel", dig_sel, 6'h3F);
    set_vec(6);
    wait_neg(3);
    check("queue_drained_mid", exp_q.size(), 0);
    #1 reset = 1'b0;

    for (int s = 0; s < 7; s++) begin
      if (s % 6 == 0) frame_vec = cur_vec;
      push_slot(s);
      wait_neg(8);
    end
    wait_neg(2);
    check("queue_drained_end", exp_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
